// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: protocol states, frame layout and default bus timing.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_RESP_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht_state_e;

    localparam int FRAME_BITS        = 40;
    localparam int FRAME_HUM_INT_MSB = 39;   // first bit on the wire is Hum_int[7]
    localparam int US_CNT_W          = 16;

    localparam int DHT_CLK_PER_US   = 50;
    localparam int DHT_START_MIN_US = 18000;
    localparam int DHT_RESP_WAIT_US = 30;
    localparam int DHT_RESP_LOW_US  = 80;
    localparam int DHT_RESP_HIGH_US = 80;
    localparam int DHT_BIT_LOW_US   = 50;
    localparam int DHT_BIT0_HIGH_US = 26;
    localparam int DHT_BIT1_HIGH_US = 70;

    function automatic logic [7:0] dht_crc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d,
                                           input logic corrupt);
        logic [7:0] sum;
        sum = a + b + c + d;
        return corrupt ? ~sum : sum;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable by clr_i.
module dht11_us_tick #(
    parameter int CLK_PER_US = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(CLK_PER_US - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 responder: detects a host start pulse and replies with the 40-bit sensor frame.
module dht11_sensor_emulator
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US   = DHT_CLK_PER_US,
    parameter int START_MIN_US = DHT_START_MIN_US,
    parameter int RESP_WAIT_US = DHT_RESP_WAIT_US,
    parameter int RESP_LOW_US  = DHT_RESP_LOW_US,
    parameter int RESP_HIGH_US = DHT_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DHT_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DHT_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DHT_BIT1_HIGH_US
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Dht_in,
    output logic       Dht_oe,
    input  logic [7:0] Hum_int,
    input  logic [7:0] Hum_float,
    input  logic [7:0] Temp_int,
    input  logic [7:0] Temp_float,
    input  logic       Crc_corrupt,
    output logic       Busy,
    output logic       Frame_done
);

    logic [1:0]            sync_q;
    logic                  din_s;
    dht_state_e            state_q, state_d;
    logic [US_CNT_W-1:0]   us_q, us_d;
    logic [US_CNT_W-1:0]   dur;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick, tick_clr, timed_done;

    assign din_s    = sync_q[1];
    assign tick_clr = (state_d != state_q);

    dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q       <= '1;
            state_q      <= ST_IDLE;
            us_q         <= '0;
            frame_q      <= '0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], Dht_in};
            state_q      <= state_d;
            us_q         <= us_d;
            frame_q      <= frame_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_RESP_WAIT: dur = US_CNT_W'(RESP_WAIT_US);
            ST_RESP_LOW:  dur = US_CNT_W'(RESP_LOW_US);
            ST_RESP_HIGH: dur = US_CNT_W'(RESP_HIGH_US);
            ST_BIT_HIGH:  dur = frame_q[FRAME_HUM_INT_MSB] ? US_CNT_W'(BIT1_HIGH_US)
                                                           : US_CNT_W'(BIT0_HIGH_US);
            default:      dur = US_CNT_W'(BIT_LOW_US);
        endcase
    end

    assign timed_done = tick && (us_q == dur - 1'b1);

    always_comb begin
        state_d      = state_q;
        us_d         = us_q;
        frame_d      = frame_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!din_s) state_d = ST_HOST_LOW;
            end
            ST_HOST_LOW: begin
                if (din_s) begin
                    if (us_q >= US_CNT_W'(START_MIN_US)) begin
                        state_d   = ST_RESP_WAIT;
                        frame_d   = {Hum_int, Hum_float, Temp_int, Temp_float,
                                     dht_crc(Hum_int, Hum_float, Temp_int, Temp_float, Crc_corrupt)};
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tick && (us_q < US_CNT_W'(START_MIN_US))) begin
                    us_d = us_q + 1'b1;
                end
            end
            ST_RESP_WAIT: if (timed_done) state_d = ST_RESP_LOW;
            ST_RESP_LOW:  if (timed_done) state_d = ST_RESP_HIGH;
            ST_RESP_HIGH: if (timed_done) state_d = ST_BIT_LOW;
            ST_BIT_LOW:   if (timed_done) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (timed_done) begin
                    frame_d   = frame_q << 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    state_d   = (bit_idx_q == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
                end
            end
            ST_END_LOW: begin
                if (timed_done) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Timed states share one µs counter; it runs from zero on every state entry.
        if (state_q != ST_IDLE && state_q != ST_HOST_LOW && tick) us_d = us_q + 1'b1;
        if (state_d != state_q) us_d = '0;
    end

    always_comb begin
        Dht_oe     = (state_q == ST_RESP_LOW) || (state_q == ST_BIT_LOW) || (state_q == ST_END_LOW);
        Busy       = (state_q != ST_IDLE) && (state_q != ST_HOST_LOW);
        Frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Directed bench for the DHT11 responder: decodes Dht_oe pulse widths against a byte scoreboard.
module tb_dht11_sensor_emulator;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Dht_in;
    logic       Dht_oe;
    logic [7:0] Hum_int = '0, Hum_float = '0, Temp_int = '0, Temp_float = '0;
    logic       Crc_corrupt = 1'b0;
    logic       Busy, Frame_done;
    logic       host_low = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    logic [7:0]  sb_q[$];
    logic [39:0] cap_bits;
    int          cap_hi[40];

    always #5 Clk = ~Clk;

    // Open-drain bus with pull-up: either side may pull it low.
    assign Dht_in = (host_low || Dht_oe) ? 1'b0 : 1'b1;

    dht11_sensor_emulator #(
        .CLK_PER_US   (1),
        .START_MIN_US (100)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Dht_in      (Dht_in),
        .Dht_oe      (Dht_oe),
        .Hum_int     (Hum_int),
        .Hum_float   (Hum_float),
        .Temp_int    (Temp_int),
        .Temp_float  (Temp_float),
        .Crc_corrupt (Crc_corrupt),
        .Busy        (Busy),
        .Frame_done  (Frame_done)
    );

    always @(negedge Clk) if (Frame_done === 1'b1) fd_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] h, input logic [7:0] hf,
                            input logic [7:0] t, input logic [7:0] tf, input logic c);
        Hum_int = h; Hum_float = hf; Temp_int = t; Temp_float = tf; Crc_corrupt = c;
    endtask

    task automatic push_frame(input logic [7:0] h, input logic [7:0] hf,
                              input logic [7:0] t, input logic [7:0] tf, input logic c);
        logic [7:0] s;
        s = h + hf + t + tf;
        sb_q.push_back(h);
        sb_q.push_back(hf);
        sb_q.push_back(t);
        sb_q.push_back(tf);
        sb_q.push_back(c ? ~s : s);
    endtask

    task automatic host_start(input int low_cycles);
        @(negedge Clk);
        host_low = 1'b1;
        repeat (low_cycles) @(negedge Clk);
        host_low = 1'b0;
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (Dht_oe === lvl && n < 300) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic capture_frame();
        int n, w;
        w = 0;
        while (Busy !== 1'b1 && w < 400) begin
            w++;
            @(negedge Clk);
        end
        check("busy_rise", Busy, 1);
        measure(1'b0, n); check("resp_wait", n, 30);
        measure(1'b1, n); check("resp_low", n, 80);
        measure(1'b0, n); check("resp_high", n, 80);
        for (int i = 0; i < 40; i++) begin
            measure(1'b1, n); check("bit_low", n, 50);
            measure(1'b0, n);
            cap_hi[i]       = n;
            cap_bits[39-i]  = (n > 48);
        end
        measure(1'b1, n); check("end_low", n, 50);
        check("frame_done", Frame_done, 1);
        check("busy_fall", Busy, 0);
        @(negedge Clk);
        check("frame_done_1cyc", Frame_done, 0);
    endtask

    task automatic check_frame();
        logic [39:0] exp_bits;
        logic [7:0]  b;
        for (int k = 0; k < 5; k++) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 1, 0);
                b = '0;
            end else begin
                b = sb_q.pop_front();
            end
            exp_bits[39-8*k -: 8] = b;
            check("frame_byte", cap_bits[39-8*k -: 8], b);
        end
        for (int i = 0; i < 40; i++)
            check("bit_high_width", cap_hi[i], exp_bits[39-i] ? 70 : 26);
    endtask

    initial begin
        int viol, rises, w, fd0;
        logic prev;

        repeat (3) @(negedge Clk);
        check("rst_oe", Dht_oe, 0);
        check("rst_busy", Busy, 0);
        check("rst_fd", Frame_done, 0);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);

        // Scenario 1: nominal frame, CRC 0x55
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        push_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        host_start(120);
        capture_frame();
        check_frame();

        // Scenario 2: start pulse below minimum is ignored
        host_start(60);
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Dht_oe !== 1'b0 || Busy !== 1'b0) viol++;
        end
        check("short_start_ignored", viol, 0);

        // Scenario 3: CRC wraps to 0x00
        set_data(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0);
        host_start(120);
        capture_frame();
        check_frame();

        // Scenario 4: corrupted CRC (0xAA)
        set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        push_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
        host_start(120);
        capture_frame();
        check_frame();
        Crc_corrupt = 1'b0;

        // Scenario 5: reset during bit 17, then a fresh frame
        host_start(120);
        rises = 0; w = 0; prev = Dht_oe;
        while (rises < 19 && w < 5000) begin
            @(negedge Clk);
            if (Dht_oe === 1'b1 && prev === 1'b0) rises++;
            prev = Dht_oe;
            w++;
        end
        check("reach_bit17", rises, 19);
        repeat (20) @(negedge Clk);
        check("bit17_oe_low_phase", Dht_oe, 1);
        Rst = 1'b1;
        @(negedge Clk);
        check("midframe_rst_oe", Dht_oe, 0);
        check("midframe_rst_busy", Busy, 0);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        push_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        host_start(120);
        capture_frame();
        check_frame();

        // Scenario 6: data change mid-frame, then back-to-back frames
        fd0 = fd_cnt;
        set_data(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        push_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        host_start(120);
        fork
            capture_frame();
            begin
                repeat (400) @(negedge Clk);
                set_data(8'h9A, 8'hBC, 8'h0D, 8'h01, 1'b0);
            end
        join
        check_frame();
        push_frame(8'h9A, 8'hBC, 8'h0D, 8'h01, 1'b0);
        host_start(120);
        capture_frame();
        check_frame();
        check("two_frame_done", fd_cnt - fd0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
